// File: rtl/isa_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// isa_pkg : ISA constants and fetch-state encoding shared by fetch and decode
// Revision: 1.0
// ---------------------------------------------------------------------------
package isa_pkg;

  localparam int OPC_W   = 5;
  localparam int INSTR_W = 16;

  // Opcodes whose instruction carries a second (immediate/EA) word
  localparam logic [OPC_W-1:0] OPC_TW_01 = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_TW_1F = 5'b11111;
  localparam logic [OPC_W-1:0] OPC_TW_1D = 5'b11101;
  localparam logic [OPC_W-1:0] OPC_TW_03 = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_TW_1C = 5'b11100;
  localparam logic [OPC_W-1:0] OPC_TW_07 = 5'b00111;
  localparam logic [OPC_W-1:0] OPC_TW_14 = 5'b10100;
  localparam logic [OPC_W-1:0] OPC_TW_15 = 5'b10101;

  typedef enum logic [0:0] {
    FETCH1 = 1'b0,
    FETCH2 = 1'b1
  } fetch_state_e;

  function automatic logic is_two_word_op(input logic [OPC_W-1:0] op);
    case (op)
      OPC_TW_01, OPC_TW_1F, OPC_TW_1D, OPC_TW_03,
      OPC_TW_1C, OPC_TW_07, OPC_TW_14, OPC_TW_15: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_predecode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_predecode : flags instruction words that need a second fetch word
// Revision: 1.0
// ---------------------------------------------------------------------------
module fetch_predecode
  import isa_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output logic               two_word_o
);

  assign two_word_o = is_two_word_op(instr_i[INSTR_W-1 -: OPC_W]);

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_unit : PC-driven instruction fetch assembling 1/2-word IF/ID bundles
// Revision: 1.0
// ---------------------------------------------------------------------------
module fetch_unit
  import isa_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [INSTR_W-1:0] if_imm,
  output logic               if_two_word,
  output logic [PC_W-1:0]    if_pc
);

  fetch_state_e         state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   hold_q, hold_d;
  logic [PC_W-1:0]      hold_pc_q, hold_pc_d;
  logic                 valid_q, valid_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [INSTR_W-1:0]   imm_q, imm_d;
  logic                 two_q, two_d;
  logic [PC_W-1:0]      ifpc_q, ifpc_d;
  logic                 w_two_word;
  logic [PC_W-1:0]      w_pc_inc;

  fetch_predecode u_predecode (
    .instr_i    (imem_data),
    .two_word_o (w_two_word)
  );

  assign w_pc_inc = pc_q + PC_W'(1);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    hold_pc_d = hold_pc_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    imm_d     = imm_q;
    two_d     = two_q;
    ifpc_d    = ifpc_q;

    // Redirect wins over stall and drops any half-assembled instruction
    if (redirect) begin
      pc_d      = redirect_pc;
      state_d   = FETCH1;
      valid_d   = 1'b0;
      hold_d    = '0;
      hold_pc_d = '0;
    end else if (!stall) begin
      pc_d = w_pc_inc;
      if (state_q == FETCH1) begin
        if (w_two_word) begin
          hold_d    = imem_data;
          hold_pc_d = pc_q;
          state_d   = FETCH2;
          valid_d   = 1'b0;
        end else begin
          instr_d = imem_data;
          imm_d   = '0;
          two_d   = 1'b0;
          ifpc_d  = pc_q;
          valid_d = 1'b1;
        end
      end else begin
        instr_d = hold_q;
        imm_d   = imem_data;
        two_d   = 1'b1;
        ifpc_d  = hold_pc_q;
        valid_d = 1'b1;
        state_d = FETCH1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH1;
      pc_q      <= RESET_PC;
      hold_q    <= '0;
      hold_pc_q <= '0;
      valid_q   <= 1'b0;
      instr_q   <= '0;
      imm_q     <= '0;
      two_q     <= 1'b0;
      ifpc_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      hold_q    <= hold_d;
      hold_pc_q <= hold_pc_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      imm_q     <= imm_d;
      two_q     <= two_d;
      ifpc_q    <= ifpc_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_imm      = two_q ? imm_q : '0;
  assign if_two_word = two_q;
  assign if_pc       = ifpc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_unit : directed scenarios plus random stall/redirect traffic
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;

  logic [15:0] imem_addr, imem_data;
  logic        if_valid, if_two_word;
  logic [15:0] if_instr, if_imm, if_pc;

  logic [15:0] imem_addr_w, imem_data_w;
  logic        if_valid_w, if_two_word_w;
  logic [15:0] if_instr_w, if_imm_w, if_pc_w;

  logic [15:0] mem [0:65535];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_data   = mem[imem_addr];
  assign imem_data_w = (imem_addr_w == 16'hFFFF) ? 16'hA000 :
                       (imem_addr_w == 16'h0000) ? 16'h00AA : 16'h2000;

  fetch_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_imm(if_imm),
    .if_two_word(if_two_word), .if_pc(if_pc)
  );

  fetch_unit #(.PC_W(16), .RESET_PC(16'hFFFF)) dut_w (
    .clk(clk), .rst(rst), .imem_addr(imem_addr_w), .imem_data(imem_data_w),
    .stall(1'b0), .redirect(1'b0), .redirect_pc(16'h0000),
    .if_valid(if_valid_w), .if_instr(if_instr_w), .if_imm(if_imm_w),
    .if_two_word(if_two_word_w), .if_pc(if_pc_w)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bundle(input string tag, input logic v, input logic [15:0] ins,
                        input logic [15:0] imm, input logic tw, input logic [15:0] pc,
                        input logic [15:0] addr);
    check({tag, ".valid"},    {15'd0, if_valid},    {15'd0, v});
    check({tag, ".instr"},    if_instr,             ins);
    check({tag, ".imm"},      if_imm,               imm);
    check({tag, ".two_word"}, {15'd0, if_two_word}, {15'd0, tw});
    check({tag, ".if_pc"},    if_pc,                pc);
    check({tag, ".imem_addr"}, imem_addr,           addr);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_two(input logic [15:0] w);
    case (w[15:11])
      5'b00001, 5'b11111, 5'b11101, 5'b00011,
      5'b11100, 5'b00111, 5'b10100, 5'b10101: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

  // Instruction-level reference: s = start address of the instruction in
  // flight, k = words already consumed; e_* = last bundle presented.
  logic [15:0] s, k, rpc, e_instr, e_imm, e_pc;
  logic        e_valid, e_two, st, rd;
  int          len;

  initial begin
    logic [4:0] tw_ops [8];
    tw_ops = '{5'b00001, 5'b11111, 5'b11101, 5'b00011,
               5'b11100, 5'b00111, 5'b10100, 5'b10101};
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;

    // Straight-line single-word stream, then a 3-cycle stall
    mem[0] = 16'h2000; mem[1] = 16'h2800; mem[2] = 16'h2000; mem[3] = 16'h3000;
    step();
    bundle("reset", 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    rst = 1'b0;
    step();
    bundle("single0", 1'b1, 16'h2000, 16'h0000, 1'b0, 16'h0000, 16'h0001);
    check("wrap.edge1.valid", {15'd0, if_valid_w}, 16'h0000);
    step();
    bundle("single1", 1'b1, 16'h2800, 16'h0000, 1'b0, 16'h0001, 16'h0002);
    check("wrap.instr", if_instr_w, 16'hA000);
    check("wrap.imm",   if_imm_w,   16'h00AA);
    check("wrap.if_pc", if_pc_w,    16'hFFFF);
    check("wrap.two",   {15'd0, if_two_word_w}, 16'h0001);
    check("wrap.pc",    imem_addr_w, 16'h0001);
    step();
    bundle("pre_stall", 1'b1, 16'h2000, 16'h0000, 1'b0, 16'h0002, 16'h0003);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      bundle("stall", 1'b1, 16'h2000, 16'h0000, 1'b0, 16'h0002, 16'h0003);
    end
    stall = 1'b0;
    step();
    bundle("resume", 1'b1, 16'h3000, 16'h0000, 1'b0, 16'h0003, 16'h0004);

    // Two-word assembly, redirect during FETCH2 under stall, reset in FETCH2
    rst = 1'b1;
    mem[0] = 16'h0800; mem[1] = 16'h1234; mem[2] = 16'hF800; mem[3] = 16'h5555;
    mem[16'h40] = 16'h2222; mem[16'h41] = 16'h0800; mem[16'h42] = 16'h7777;
    step();
    rst = 1'b0;
    step();
    bundle("tw.bubble", 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0001);
    step();
    bundle("tw.bundle", 1'b1, 16'h0800, 16'h1234, 1'b1, 16'h0000, 16'h0002);
    step();
    check("tw2.bubble.valid", {15'd0, if_valid}, 16'h0000);
    check("tw2.bubble.addr", imem_addr, 16'h0003);
    stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    check("redir.valid", {15'd0, if_valid}, 16'h0000);
    check("redir.addr",  imem_addr, 16'h0040);
    stall = 1'b0; redirect = 1'b0;
    step();
    bundle("redir.target", 1'b1, 16'h2222, 16'h0000, 1'b0, 16'h0040, 16'h0041);
    step();
    check("pre_rst.valid", {15'd0, if_valid}, 16'h0000);
    check("pre_rst.addr",  imem_addr, 16'h0042);
    rst = 1'b1;
    #1;
    bundle("async_rst", 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);

    // Random traffic against the instruction-level model
    for (int i = 0; i < 65536; i++) begin
      if ($urandom_range(0, 2) == 0)
        mem[i] = {tw_ops[$urandom_range(0, 7)], 11'($urandom)};
      else
        mem[i] = 16'($urandom);
    end
    step();
    rst = 1'b0;
    s = 16'h0000; k = 16'h0000;
    e_valid = 1'b0; e_instr = 16'h0; e_imm = 16'h0; e_two = 1'b0; e_pc = 16'h0;
    for (int c = 0; c < 600; c++) begin
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      stall = st; redirect = rd; redirect_pc = rpc;
      step();
      if (rd) begin
        s = rpc; k = 16'h0000; e_valid = 1'b0;
      end else if (!st) begin
        len = is_two(mem[s]) ? 2 : 1;
        k = k + 16'h0001;
        if (int'(k) == len) begin
          e_valid = 1'b1;
          e_instr = mem[s];
          e_two   = (len == 2);
          e_imm   = (len == 2) ? mem[16'(s + 16'h0001)] : 16'h0000;
          e_pc    = s;
          s = 16'(s + 16'(len));
          k = 16'h0000;
        end else begin
          e_valid = 1'b0;
        end
      end
      bundle("rand", e_valid, e_instr, e_imm, e_two, e_pc, 16'(s + k));
    end
    stall = 1'b0; redirect = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
